// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO data manager: IO register map, default IO window
// base and the address-region decode used by the top level.
package mmio_pkg;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'h0001_0000;

    localparam logic [3:0] LED_OFS       = 4'h0;
    localparam logic [3:0] BTN_LEVEL_OFS = 4'h4;
    localparam logic [3:0] BTN_EVENT_OFS = 4'h8;
    localparam logic [3:0] CYCLES_OFS    = 4'hC;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_IO,
        REG_NONE
    } region_e;

    // The IO window is exactly four words, so anything past offset 0xC is unmapped.
    function automatic region_e decode_region(input logic [31:0] addr,
                                              input logic [31:0] ram_bytes,
                                              input logic [31:0] io_base);
        region_e region;
        region = REG_NONE;
        if (addr < ram_bytes) begin
            region = REG_RAM;
        end else if (addr[31:4] == io_base[31:4]) begin
            region = REG_IO;
        end
        return region;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Single-button two-flop synchroniser plus debounce counter; the level follows the
// synchronised input once it has disagreed for DEBOUNCE_CYCLES consecutive cycles.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic CLK,
    input  logic RST,
    input  logic button_i,
    output logic level_o,
    output logic rise_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;

    always_comb begin
        sync_d  = {sync_q[0], button_i};
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync_q[1] == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            // This cycle completes the required run of disagreeing samples.
            level_d = sync_q[1];
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level_o = level_q;
    // Combinational so the event flag lands on the same edge as the level.
    assign rise_o  = ~RST & level_d & ~level_q;

endmodule

// File: rtl/mmio_data_manager.sv
// CPU data-port manager: word RAM plus an IO window with debounced buttons, sticky
// button events, an LED register and a free-running cycle counter; reads take one cycle.
module mmio_data_manager
    import mmio_pkg::*;
#(
    parameter int          DATA_W          = 32,
    parameter int          RAM_DEPTH       = 1024,
    parameter logic [31:0] IO_BASE         = IO_BASE_DEFAULT,
    parameter int          NUM_BUTTONS     = 4,
    parameter int          NUM_LEDS        = 8,
    parameter int          DEBOUNCE_CYCLES = 50000
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [31:0]            address_i,
    input  logic [DATA_W-1:0]      data_i,
    input  logic                   wren_i,
    input  logic [NUM_BUTTONS-1:0] button_i,
    output logic [DATA_W-1:0]      data_o,
    output logic [NUM_LEDS-1:0]    LEDs_o
);

    localparam int          RAM_AW    = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam logic [31:0] RAM_BYTES = 32'(RAM_DEPTH) << 2;

    region_e               region, region_q;
    logic [3:0]            io_ofs;
    logic [RAM_AW-1:0]     ram_idx;
    logic                  ram_we;
    logic                  io_we;

    logic [NUM_BUTTONS-1:0] btn_level;
    logic [NUM_BUTTONS-1:0] btn_rise;

    logic [NUM_LEDS-1:0]    led_q, led_d;
    logic [NUM_BUTTONS-1:0] evt_q, evt_d;
    logic [DATA_W-1:0]      cycles_q, cycles_d;
    logic [DATA_W-1:0]      io_rdata_q, io_rdata_d;
    logic [DATA_W-1:0]      ram_rdata_q;
    logic [DATA_W-1:0]      ram_q [RAM_DEPTH];

    assign region  = decode_region(address_i, RAM_BYTES, IO_BASE);
    assign io_ofs  = {address_i[3:2], 2'b00};
    assign ram_idx = address_i[RAM_AW+1:2];
    assign ram_we  = wren_i && !RST && (region == REG_RAM);
    assign io_we   = wren_i && (region == REG_IO);

    for (genvar b = 0; b < NUM_BUTTONS; b++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debouncer (
            .CLK     (CLK),
            .RST     (RST),
            .button_i(button_i[b]),
            .level_o (btn_level[b]),
            .rise_o  (btn_rise[b])
        );
    end

    always_comb begin
        led_d    = led_q;
        evt_d    = evt_q;
        cycles_d = cycles_q + DATA_W'(1);
        if (io_we) begin
            case (io_ofs)
                LED_OFS:       led_d    = data_i[NUM_LEDS-1:0];
                BTN_EVENT_OFS: evt_d    = evt_q & ~data_i[NUM_BUTTONS-1:0];
                CYCLES_OFS:    cycles_d = data_i;
                default:       ;
            endcase
        end
        // Applied after the clear so a coincident new press survives.
        evt_d = evt_d | btn_rise;
    end

    always_comb begin
        io_rdata_d = '0;
        if (region == REG_IO) begin
            case (io_ofs)
                LED_OFS:       io_rdata_d[NUM_LEDS-1:0]    = led_q;
                BTN_LEVEL_OFS: io_rdata_d[NUM_BUTTONS-1:0] = btn_level;
                BTN_EVENT_OFS: io_rdata_d[NUM_BUTTONS-1:0] = evt_q;
                CYCLES_OFS:    io_rdata_d                  = cycles_q;
                default:       ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            led_q      <= '0;
            evt_q      <= '0;
            cycles_q   <= '0;
            io_rdata_q <= '0;
            region_q   <= REG_NONE;
        end else begin
            led_q      <= led_d;
            evt_q      <= evt_d;
            cycles_q   <= cycles_d;
            io_rdata_q <= io_rdata_d;
            region_q   <= region;
        end
    end

    // Read-first single-port RAM; contents survive reset.
    always_ff @(posedge CLK) begin
        if (ram_we) begin
            ram_q[ram_idx] <= data_i;
        end
        ram_rdata_q <= ram_q[ram_idx];
    end

    assign data_o = (region_q == REG_RAM) ? ram_rdata_q : io_rdata_q;
    assign LEDs_o = led_q;

endmodule

// File: tb/tb_mmio_data_manager.sv
// Bench for mmio_data_manager: a cycle-level memory-map model checked every cycle,
// plus directed vectors with hand-computed expectations.
module tb_mmio_data_manager;

    localparam int          DW  = 32;
    localparam int          RD  = 1024;
    localparam int          NB  = 4;
    localparam int          NL  = 8;
    localparam int          DB  = 4;
    localparam logic [31:0] IOB = 32'h0001_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   addr = '0;
    logic [DW-1:0] wdata = '0;
    logic          wren = 1'b0;
    logic [NB-1:0] btn = '0;
    logic [DW-1:0] data_o;
    logic [NL-1:0] leds;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mmio_data_manager #(
        .DATA_W         (DW),
        .RAM_DEPTH      (RD),
        .IO_BASE        (IOB),
        .NUM_BUTTONS    (NB),
        .NUM_LEDS       (NL),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .CLK      (clk),
        .RST      (rst),
        .address_i(addr),
        .data_i   (wdata),
        .wren_i   (wren),
        .button_i (btn),
        .data_o   (data_o),
        .LEDs_o   (leds)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory-map model, advanced once per rising edge from the same inputs the DUT sees.
    logic [31:0] m_ram [int];
    logic [NL-1:0] m_led;
    logic [NB-1:0] m_lvl, m_evt, m_s1, m_s2;
    logic [31:0] m_cyc;
    int          m_run [NB];
    logic [31:0] exp_data;
    bit          exp_known;
    bit          model_ok = 1'b0;

    always @(posedge clk) begin
        logic [NB-1:0] synced;
        logic [NB-1:0] rise;
        logic [NB-1:0] clr;
        if (rst) begin
            m_led = '0; m_lvl = '0; m_evt = '0; m_cyc = '0; m_s1 = '0; m_s2 = '0;
            for (int b = 0; b < NB; b++) m_run[b] = 0;
            exp_data  = '0;
            exp_known = 1'b1;
        end else begin
            exp_known = 1'b1;
            exp_data  = '0;
            if (addr < RD * 4) begin
                if (m_ram.exists(int'(addr >> 2))) exp_data = m_ram[int'(addr >> 2)];
                else exp_known = 1'b0;
            end else if (addr >= IOB && addr < IOB + 32'd16) begin
                case ((addr - IOB) >> 2)
                    0: exp_data = 32'(m_led);
                    1: exp_data = 32'(m_lvl);
                    2: exp_data = 32'(m_evt);
                    default: exp_data = m_cyc;
                endcase
            end
            synced = m_s2;
            m_s2   = m_s1;
            m_s1   = btn;
            rise   = '0;
            for (int b = 0; b < NB; b++) begin
                if (synced[b] != m_lvl[b]) begin
                    m_run[b]++;
                    if (m_run[b] == DB) begin
                        m_lvl[b] = synced[b];
                        rise[b]  = synced[b];
                        m_run[b] = 0;
                    end
                end else begin
                    m_run[b] = 0;
                end
            end
            clr   = '0;
            m_cyc = m_cyc + 32'd1;
            if (wren) begin
                if (addr < RD * 4) begin
                    m_ram[int'(addr >> 2)] = wdata;
                end else if (addr >= IOB && addr < IOB + 32'd16) begin
                    case ((addr - IOB) >> 2)
                        0: m_led = wdata[NL-1:0];
                        2: clr   = wdata[NB-1:0];
                        3: m_cyc = wdata;
                        default: ;
                    endcase
                end
            end
            m_evt = (m_evt & ~clr) | rise;
        end
        model_ok = 1'b1;
    end

    always @(negedge clk) begin
        if (model_ok) begin
            if (exp_known) check("data_o", data_o, exp_data);
            check("LEDs_o", 32'(leds), 32'(m_led));
        end
    end

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic we);
        addr  = a;
        wdata = d;
        wren  = we;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 0);
        drive(0, 0, 0);
        check("rst_data", data_o, 32'h0);
        check("rst_leds", 32'(leds), 32'h0);
        rst = 1'b0;
        drive(IOB + 12, 0, 0);
        check("rst_cycles", data_o, 32'h0);
        drive(IOB + 8, 0, 0);
        check("rst_event", data_o, 32'h0);

        drive(32'h10, 32'hDEAD_BEEF, 1);
        drive(32'h0, 32'h1111_1111, 1);
        drive(32'hFFC, 32'hA5A5_0FFC, 1);
        drive(32'h10, 0, 0);
        check("ram_rd_10", data_o, 32'hDEAD_BEEF);
        drive(32'h14, 0, 0);
        drive(32'h10, 0, 0);
        check("ram_10_after_14", data_o, 32'hDEAD_BEEF);
        drive(32'h13, 0, 0);
        check("ram_low_bits_ignored", data_o, 32'hDEAD_BEEF);
        drive(32'h10, 32'hCAFE_F00D, 1);
        check("ram_rdw_old", data_o, 32'hDEAD_BEEF);
        drive(32'h10, 0, 0);
        check("ram_rd_new", data_o, 32'hCAFE_F00D);
        drive(32'hFFC, 0, 0);
        check("ram_last_word", data_o, 32'hA5A5_0FFC);

        drive(IOB, 32'h1A5, 1);
        check("led_out", 32'(leds), 32'hA5);
        drive(IOB, 0, 0);
        check("led_rd", data_o, 32'h0000_00A5);
        drive(IOB, 32'h3C, 1);
        check("led_rdw_old", data_o, 32'hA5);
        check("led_out2", 32'(leds), 32'h3C);

        btn = 4'b0100;
        repeat (3) drive(IOB + 4, 0, 0);
        btn = 4'b0000;
        repeat (8) drive(IOB + 4, 0, 0);
        check("glitch_level", data_o, 32'h0);
        drive(IOB + 8, 0, 0);
        check("glitch_event", data_o, 32'h0);

        btn = 4'b0100;
        repeat (6) drive(IOB + 4, 0, 0);
        check("level_before_6", data_o, 32'h0);
        drive(IOB + 8, 0, 0);
        check("event_at_6", data_o, 32'h4);
        drive(IOB + 4, 0, 0);
        check("level_at_6", data_o, 32'h4);
        drive(IOB + 8, 32'h4, 1);
        check("evt_clr_rdw", data_o, 32'h4);
        drive(IOB + 8, 0, 0);
        check("evt_cleared", data_o, 32'h0);
        drive(IOB + 4, 0, 0);
        check("level_kept", data_o, 32'h4);

        btn = 4'b1101;
        repeat (8) drive(IOB + 4, 0, 0);
        check("level_multi", data_o, 32'hD);
        drive(IOB + 8, 0, 0);
        check("event_multi", data_o, 32'h9);
        drive(IOB + 4, 32'h0, 1);
        drive(IOB + 4, 0, 0);
        check("level_ro", data_o, 32'hD);

        btn = 4'b1001;
        repeat (10) drive(IOB + 4, 0, 0);
        check("level_release", data_o, 32'h9);
        drive(IOB + 8, 32'h9, 1);
        btn = 4'b1101;
        repeat (5) drive(IOB + 8, 0, 0);
        drive(IOB + 8, 32'h4, 1);
        check("evt_pre_rise", data_o, 32'h0);
        drive(IOB + 8, 0, 0);
        check("set_beats_clear", data_o, 32'h4);

        drive(IOB + 12, 32'hFFFF_FFFE, 1);
        drive(IOB + 12, 0, 0);
        check("cyc_loaded", data_o, 32'hFFFF_FFFE);
        drive(IOB + 12, 0, 0);
        check("cyc_max", data_o, 32'hFFFF_FFFF);
        drive(IOB + 12, 0, 0);
        check("cyc_wrap", data_o, 32'h0);
        drive(IOB + 12, 0, 0);
        check("cyc_after_wrap", data_o, 32'h1);

        drive(IOB + 16, 32'h55, 1);
        check("unm_io_rdw", data_o, 32'h0);
        drive(IOB + 16, 0, 0);
        check("unm_io_rd", data_o, 32'h0);
        drive(RD * 4, 32'h77, 1);
        drive(RD * 4, 0, 0);
        check("unm_ram_rd", data_o, 32'h0);
        drive(32'hFFFC, 32'h99, 1);
        drive(32'h0, 0, 0);
        check("ram0_intact", data_o, 32'h1111_1111);
        drive(32'hFFC, 0, 0);
        check("ram_last_intact", data_o, 32'hA5A5_0FFC);
        drive(IOB, 0, 0);
        check("led_intact", data_o, 32'h3C);
        drive(IOB + 8, 0, 0);
        check("event_intact", data_o, 32'h4);

        btn = 4'b0000;
        repeat (10) drive(IOB + 4, 0, 0);
        btn = 4'b0010;
        repeat (4) drive(IOB + 4, 0, 0);
        rst = 1'b1;
        drive(IOB + 4, 0, 0);
        rst = 1'b0;
        repeat (6) drive(IOB + 4, 0, 0);
        check("rst_discard_pre", data_o, 32'h0);
        drive(IOB + 4, 0, 0);
        check("rst_discard_post", data_o, 32'h2);
        drive(32'h10, 0, 0);
        check("ram_not_reset", data_o, 32'hCAFE_F00D);
        check("leds_after_rst", 32'(leds), 32'h0);

        drive(0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
